// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 multicycle control path: opcodes, ALU codes,
// datapath mux selects and the control FSM state type.
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps funct3/funct7b5 of R- and I-type ALU instructions to an ALU op code,
// flagging encodings the ALU does not implement.
module riscv_alu_decoder
    import riscv_pkg::*;
(
    input  logic       is_rtype_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_op_o,
    output logic       legal_o
);

    // funct7b5 only selects SUB on R-type; on I-type it is immediate bits
    logic r_alt;
    assign r_alt = is_rtype_i & funct7b5_i;

    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b0;
        case (funct3_i)
            3'b000: begin alu_op_o = r_alt ? ALU_SUB : ALU_ADD; legal_o = 1'b1;   end
            3'b010: begin alu_op_o = ALU_SLT;                   legal_o = !r_alt; end
            3'b110: begin alu_op_o = ALU_OR;                    legal_o = !r_alt; end
            3'b111: begin alu_op_o = ALU_AND;                   legal_o = !r_alt; end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, ALU op and write strobes.
module riscv_mc_control
    import riscv_pkg::*;
#(
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_op,
    output logic       trap
);

    state_t     state_q, state_d;
    logic [2:0] dec_op;
    logic       dec_legal;
    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;
    state_t     illegal_next;

    riscv_alu_decoder u_alu_dec (
        .is_rtype_i (opcode == OP_R),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .alu_op_o   (dec_op),
        .legal_o    (dec_legal)
    );

    assign illegal_next = STRICT_DECODE ? S_TRAP : S_FETCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = dec_legal ? S_EXEC_R : illegal_next;
                    OP_I:         state_d = dec_legal ? S_EXEC_I : illegal_next;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = illegal_next;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = ADR_PC;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALU_ADD;
        trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = ADR_ALUOUT;
            S_MEMWB: begin
                result_src  = RES_MEM;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = ADR_ALUOUT;
                mem_write_c = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = dec_op;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_op;
            end
            S_ALUWB:    reg_write_c = 1'b1;
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_SUB;
                pc_write_c = zero;
            end
            // ALUOut still holds the DECODE branch target; rd gets oldPC+4 via ALUWB
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
            end
            S_TRAP:     trap = 1'b1;
            default: ;
        endcase
    end

    // Strobes are gated directly by rst_n so nothing fires during an async reset
    assign pc_write  = pc_write_c  & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed scoreboard bench for riscv_mc_control: each stimulus cycle queues
// the hand-derived output vector, a negedge monitor pops and compares.
module tb_riscv_mc_control;

    logic       clk, rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;
    exp_t sbq[$];

    riscv_mc_control #(.STRICT_DECODE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_op(alu_op), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, src_a, src_b, imm_src, alu_op, trap}
    function automatic logic [16:0] ev(logic pcw, logic adr, logic irw, logic mw, logic rw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic [1:0] im, logic [2:0] op, logic tr);
        return {pcw, adr, irw, mw, rw, rs, sa, sb, im, op, tr};
    endfunction

    function automatic logic [16:0] e_fetch(logic mr, logic [1:0] im);
        return ev(mr, 0, mr, 0, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0);
    endfunction
    function automatic logic [16:0] e_dec(logic [1:0] im);    return ev(0,0,0,0,0,2'b00,2'b01,2'b01,im,3'b000,0); endfunction
    function automatic logic [16:0] e_madr(logic [1:0] im);   return ev(0,0,0,0,0,2'b00,2'b10,2'b01,im,3'b000,0); endfunction
    function automatic logic [16:0] e_mrd(logic [1:0] im);    return ev(0,1,0,0,0,2'b00,2'b00,2'b00,im,3'b000,0); endfunction
    function automatic logic [16:0] e_mwb(logic [1:0] im);    return ev(0,0,0,0,1,2'b01,2'b00,2'b00,im,3'b000,0); endfunction
    function automatic logic [16:0] e_mwr(logic [1:0] im);    return ev(0,1,0,1,0,2'b00,2'b00,2'b00,im,3'b000,0); endfunction
    function automatic logic [16:0] e_exr(logic [2:0] op);    return ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,op,0);  endfunction
    function automatic logic [16:0] e_exi(logic [2:0] op);    return ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,op,0);  endfunction
    function automatic logic [16:0] e_awb(logic [1:0] im);    return ev(0,0,0,0,1,2'b00,2'b00,2'b00,im,3'b000,0); endfunction
    function automatic logic [16:0] e_beq(logic z);           return ev(z,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0); endfunction
    function automatic logic [16:0] e_jal();                  return ev(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0); endfunction
    function automatic logic [16:0] e_trap(logic [1:0] im);   return ev(0,0,0,0,0,2'b00,2'b00,2'b00,im,3'b000,1); endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic [16:0] act;
            e   = sbq.pop_front();
            act = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                   alu_src_a, alu_src_b, imm_src, alu_op, trap};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.v);
            end
        end
    end

    task automatic step(string name, logic [16:0] exp, logic mr = 1'b1, logic z = 1'b0);
        mem_ready = mr;
        zero      = z;
        sbq.push_back('{v: exp, name: name});
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic f7);
        opcode = op; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic alu_instr(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic [2:0] exp_op);
        set_instr(op, f3, f7);
        step({name, "_fetch"}, e_fetch(1, 2'b00));
        step({name, "_decode"}, e_dec(2'b00));
        step({name, "_exec"}, (op == 7'b0110011) ? e_exr(exp_op) : e_exi(exp_op));
        step({name, "_aluwb"}, e_awb(2'b00));
    endtask

    task automatic illegal_instr(string name, logic [6:0] op, logic [2:0] f3, logic f7, int hold);
        set_instr(op, f3, f7);
        step({name, "_fetch"}, e_fetch(1, 2'b00));
        step({name, "_decode"}, e_dec(2'b00));
        for (int i = 0; i < hold; i++) step({name, "_trap"}, e_trap(2'b00), logic'(i % 2));
        rst_n = 1'b0;
        step({name, "_in_reset"}, e_fetch(0, 2'b00), 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(7'b0, 3'b0, 1'b0);
        zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        step("reset_state", e_fetch(0, 2'b00), 1'b1);
        rst_n = 1'b1;

        alu_instr("add",  7'b0110011, 3'b000, 1'b0, 3'b000);
        step("add_back_fetch", e_fetch(0, 2'b00), 1'b0);   // also a FETCH stall cycle
        alu_instr("sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
        alu_instr("slt",  7'b0110011, 3'b010, 1'b0, 3'b010);
        alu_instr("or",   7'b0110011, 3'b110, 1'b0, 3'b011);
        alu_instr("and",  7'b0110011, 3'b111, 1'b0, 3'b100);
        alu_instr("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
        alu_instr("andi", 7'b0010011, 3'b111, 1'b1, 3'b100);

        set_instr(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch",  e_fetch(1, 2'b00));
        step("lw_decode", e_dec(2'b00));
        step("lw_memadr", e_madr(2'b00), 1'b0);
        for (int i = 0; i < 3; i++) step("lw_memread_wait", e_mrd(2'b00), 1'b0);
        step("lw_memread_done", e_mrd(2'b00), 1'b1);
        step("lw_memwb", e_mwb(2'b00), 1'b0);

        set_instr(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch",   e_fetch(1, 2'b01));
        step("sw_decode",  e_dec(2'b01));
        step("sw_memadr",  e_madr(2'b01));
        step("sw_memwrite", e_mwr(2'b01), 1'b1);

        set_instr(7'b1100011, 3'b000, 1'b0);
        step("beq_t_fetch",  e_fetch(1, 2'b10));
        step("beq_t_decode", e_dec(2'b10));
        step("beq_taken",    e_beq(1'b1), 1'b1, 1'b1);
        step("beq_nt_fetch", e_fetch(1, 2'b10));
        step("beq_nt_decode", e_dec(2'b10), 1'b1, 1'b1);
        step("beq_not_taken", e_beq(1'b0), 1'b1, 1'b0);

        set_instr(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch",  e_fetch(1, 2'b11));
        step("jal_decode", e_dec(2'b11));
        step("jal_jal",    e_jal());
        step("jal_aluwb",  e_awb(2'b11));

        illegal_instr("ecall",   7'b1110011, 3'b000, 1'b0, 10);
        step("after_trap_fetch", e_fetch(0, 2'b00), 1'b0);
        illegal_instr("r_f3_001", 7'b0110011, 3'b001, 1'b0, 2);
        illegal_instr("r_or_f7",  7'b0110011, 3'b110, 1'b1, 2);
        illegal_instr("i_f3_100", 7'b0010011, 3'b100, 1'b0, 2);

        // reset dropped while a store is waiting on memory
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("rsw_fetch",  e_fetch(1, 2'b01));
        step("rsw_decode", e_dec(2'b01));
        step("rsw_memadr", e_madr(2'b01));
        step("rsw_memwrite", e_mwr(2'b01), 1'b0);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rsw_before_reset: mem_write got %b expected 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, adr_src} !== 2'b00) begin
            errors++;
            $display("FAIL rsw_async_drop: {mem_write,adr_src} got %b expected 00", {mem_write, adr_src});
        end
        @(posedge clk); #1;
        step("rsw_in_reset", e_fetch(0, 2'b01), 1'b1);
        rst_n = 1'b1;
        step("rsw_fetch_stall", e_fetch(0, 2'b01), 1'b0);
        step("rsw_fetch_go",    e_fetch(1, 2'b01), 1'b1);
        step("rsw_decode2",     e_dec(2'b01));

        @(negedge clk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
